// File: rtl/texel_stream_assembler.sv
// ---------------------------------------------------------------------------
// texel_stream_assembler
//
// Parses framed records (FRAME_START, WORDS payload words, FRAME_END) from the
// AHB user read buffer, unpacks each payload into a flat texel record and
// queues complete records in a DEPTH-entry FIFO for the rasteriser.
//
// Ports
//   clk                   system clock
//   n_rst                 synchronous active-low reset
//   ahb_buffer            current AHB word
//   ahb_data_available    ahb_buffer holds a valid word
//   ahb_user_read_buffer  word accepted this cycle (pops the AHB buffer)
//   texel_read            consumer pops the FIFO head
//   texel_data_out        FIFO head record (zero while the FIFO is empty)
//   texel_ready           FIFO non-empty
//   fifo_count            records queued
//   frame_error           one-cycle pulse after a bad END word
//   err_count             saturating framing-error count
//
// Record layout from bit 0: p.x p.y p.z q.x q.y q.z r.x r.y r.z (COORD_W
// each), then colour r g b (CHAN_W each). Payload word k fills record bits
// [k*BUS_W +: BUS_W]; last-word bits at or above REC_W are dropped.
//
// Handshakes: a word moves from the AHB buffer when ahb_data_available and
// ahb_user_read_buffer are both high on a clk edge; a record leaves the FIFO
// when texel_read and texel_ready are both high on a clk edge. texel_read
// while the FIFO is empty is ignored.
// ---------------------------------------------------------------------------
module texel_stream_assembler #(
  parameter int BUS_W   = 32,
  parameter int COORD_W = 16,
  parameter int VERTS   = 3,
  parameter int CHAN_W  = 8,
  parameter int DEPTH   = 2,
  parameter logic [BUS_W-1:0] FRAME_START = BUS_W'(0),
  parameter logic [BUS_W-1:0] FRAME_END   = BUS_W'(1),
  localparam int REC_W = 3 * VERTS * COORD_W + 3 * CHAN_W,
  localparam int WORDS = (REC_W + BUS_W - 1) / BUS_W,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [BUS_W-1:0] ahb_buffer,
  input  logic             ahb_data_available,
  output logic             ahb_user_read_buffer,
  input  logic             texel_read,
  output logic [REC_W-1:0] texel_data_out,
  output logic             texel_ready,
  output logic [CW-1:0]    fifo_count,
  output logic             frame_error,
  output logic [7:0]       err_count
);

  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   word_cnt;
  logic [REC_W-1:0]   asm_reg;
  logic               ferr_q;
  logic [7:0]         err_q;

  logic [REC_W-1:0]   fifo_mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;

  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic tail_word;
  logic is_start;
  logic is_end;
  logic push;
  logic bad_end;
  logic pop;

  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign is_start   = (ahb_buffer == FRAME_START);
  assign is_end     = (ahb_buffer == FRAME_END);

  // Only the END slot waits for FIFO space; HUNT and DATA keep draining the
  // AHB buffer so the next record assembles under backpressure. No path from
  // texel_read reaches this signal.
  assign accept    = ahb_data_available && !((state == ST_TAIL) && fifo_full);
  assign tail_word = accept && (state == ST_TAIL);
  assign push      = tail_word && is_end;
  assign bad_end   = tail_word && !is_end;
  assign pop       = texel_read && !fifo_empty;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Frame parser
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= ST_HUNT;
      word_cnt <= '0;
      asm_reg  <= '0;
      ferr_q   <= 1'b0;
      err_q    <= 8'd0;
    end else begin
      ferr_q <= bad_end;
      if (bad_end && (err_q != 8'hFF)) begin
        err_q <= err_q + 8'd1;
      end
      if (accept) begin
        case (state)
          ST_HUNT: begin
            if (is_start) begin
              state    <= ST_DATA;
              word_cnt <= '0;
            end
          end
          ST_DATA: begin
            // Bit-wise scatter keeps every index constant and drops the
            // last-word bits that fall beyond the record.
            for (int b = 0; b < REC_W; b++) begin
              if (word_cnt == CNT_W'(b / BUS_W)) begin
                asm_reg[b] <= ahb_buffer[b % BUS_W];
              end
            end
            if (word_cnt == CNT_W'(WORDS - 1)) begin
              state <= ST_TAIL;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
          ST_TAIL: begin
            word_cnt <= '0;
            // A START in the END slot is an error but also a fresh frame.
            state <= is_start ? ST_DATA : ST_HUNT;
          end
          default: begin
            state    <= ST_HUNT;
            word_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Output FIFO control
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the read port is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= asm_reg;
    end
  end

  assign ahb_user_read_buffer = accept;
  assign texel_data_out       = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign texel_ready          = !fifo_empty;
  assign fifo_count           = count;
  assign frame_error          = ferr_q;
  assign err_count            = err_q;

endmodule

// File: doc/texel_stream_assembler.md
# texel_stream_assembler

Parametrised successor to the single-record texel assembler. It consumes 32-bit words from the AHB user read buffer and parses framed records of the form FRAME_START, payload words, FRAME_END. Each payload is unpacked into a flat texel record of triangle vertices plus colour, and complete records are queued in a DEPTH-entry output FIFO. Framing is validated: bad frames are dropped, counted and resynchronised, while the rasteriser-side consumer drains records with a ready/read handshake.

## Interface
Parameters:
- BUS_W, 32: AHB word width.
- COORD_W, 16: width of one vertex coordinate.
- VERTS, 3: vertices per primitive.
- CHAN_W, 8: width of one colour channel (R, G, B).
- DEPTH, 2: output FIFO depth in records, ≥1.
- FRAME_START, 32'd0: start marker.
- FRAME_END, 32'd1: end marker.
- Derived:
  - REC_W = 3·VERTS·COORD_W + 3·CHAN_W (168 at defaults).
  - WORDS = ceil(REC_W/BUS_W) (6 at defaults).
  - CW = $clog2(DEPTH+1).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset, synchronous, active-low.
- ahb_buffer  in  BUS_W  current AHB word.
- ahb_data_available  in  1  ahb_buffer holds a valid word.
- ahb_user_read_buffer  out  1  word accepted this cycle (pop of AHB buffer).
- texel_read  in  1  consumer pops FIFO head.
- texel_data_out  out  REC_W  FIFO head record.
- texel_ready  out  1  FIFO non-empty.
- fifo_count  out  CW  records queued.
- frame_error  out  1  one-cycle pulse on a bad END word.
- err_count  out  8  saturating framing-error count.

## Operation
- A word is accepted when ahb_user_read_buffer = 1: ahb_data_available && !(state==TAIL && fifo full). This output is combinational from state, FIFO count and ahb_data_available only, with no path from texel_read.
- Record packing is little-endian. Payload word k supplies record bits [k·BUS_W +: BUS_W]. Field order from bit 0:
  - p.x, p.y, p.z, q.x, q.y, q.z, r.x, r.y, r.z, each COORD_W;
  - then colour r, g, b, each CHAN_W.
  - Last-word bits at or above REC_W are ignored.
- FSM states, with transitions on accepted words only:
  - HUNT: word == FRAME_START → DATA with word counter = 0. Any other word is discarded.
  - DATA: write the word into the assembly register at the counter position. At counter == WORDS-1 → TAIL, otherwise increment. Marker values carry no meaning in DATA; they are stored as payload.
  - TAIL:
    - word == FRAME_END: push the assembly register into the FIFO, → HUNT.
    - word == FRAME_START: frame_error = 1, err_count +1 (saturating at 255), no push, → DATA with counter 0 (immediate resync).
    - any other word: frame_error = 1, err_count +1, no push, → HUNT.
- FIFO behaviour:
  - texel_read while texel_ready pops the head.
  - texel_read while the FIFO is empty is ignored.
  - A push and a pop in the same cycle leave fifo_count unchanged. Head order is preserved.
  - A push never occurs when the FIFO is full, because acceptance is gated in TAIL.
- DATA and HUNT keep accepting while the FIFO is full, so the next record assembles during backpressure.
- DEPTH = 1 gives the legacy one-record-buffer behaviour.

## Timing
- Synchronous reset (n_rst = 0 at a clk edge) sets:
  - state = HUNT, counter = 0, FIFO empty, assembly register = 0;
  - texel_data_out = 0, texel_ready = 0, fifo_count = 0, frame_error = 0, err_count = 0.
  - ahb_user_read_buffer then equals ahb_data_available.
- Reset mid-record discards the partial record.
- Latency:
  - FRAME_END accepted at edge N → texel_ready = 1 and texel_data_out valid after edge N.
  - A pop at edge N: the next head, or texel_ready = 0, appears after edge N.
- frame_error is registered: high for exactly the cycle after the offending edge.
- Minimum frame is WORDS+2 cycles. Back-to-back frames with no idle cycles are supported.
- Wrap-around: FIFO pointers wrap modulo DEPTH, and fifo_count never exceeds DEPTH.

## Test plan
- Nominal frame. Stimulus: 0, 33221100, 77665544, BBAA9988, FFEEDDCC, 76543210, FEDBCA98, 1, one word per cycle, avail = 1. Required response:
  - ahb_user_read_buffer = 1 for all 8 words;
  - after the END edge: texel_ready = 1, fifo_count = 1;
  - fields: p = (1100, 3322, 5544), q = (7766, 9988, BBAA), r = (DDCC, FFEE, 3210), colour = (54, 76, 98).
- Backpressure at DEPTH = 2. Stimulus: three frames, no texel_read. Required response:
  - fifo_count = 2;
  - third frame stalls in TAIL with ahb_user_read_buffer = 0;
  - pulse texel_read for one cycle → END accepted on the following edge, fifo_count = 2, head = second record.
- Framing error. Stimulus: END replaced by 12345678. Required response:
  - frame_error pulses for 1 cycle, err_count = 1, fifo_count = 0, state returns to HUNT;
  - the next valid frame is queued normally.
- Hunt and resync. Stimulus: DEADBEEF, DEADBEEF, then a valid frame → both garbage words consumed and dropped, record correct. Second stimulus: START in the END slot → err_count +1, and that START begins a new frame that assembles correctly.
- Reset mid-record. Stimulus: n_rst = 0 for 1 cycle after 3 payload words. Required response:
  - all outputs 0;
  - a subsequent full frame gives the nominal record.
- Simultaneous push and pop. Stimulus: fifo_count = 1, texel_read asserted on the END edge of the second frame → fifo_count stays 1, head = second record. Also: texel_read while empty → no change to any output.
